// File: rtl/six_one_mux.sv
// rtl/six_one_mux.sv - registered 6-to-1 mux with illegal-select flag; optional q_par via SIX_ONE_MUX_PARITY_EN
module six_one_mux #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [WIDTH-1:0] d4,
  input  logic [WIDTH-1:0] d5,
  output logic [WIDTH-1:0] q,
  output logic             out_valid,
`ifdef SIX_ONE_MUX_PARITY_EN
  output logic             q_par,
`endif
  output logic             sel_err
);

  logic [WIDTH-1:0] mux_d;
  logic             sel_legal;

  // Codes 6 and 7 steer zero into q so an illegal transfer never leaks stale data.
  always_comb begin
    mux_d     = '0;
    sel_legal = 1'b1;
    case (sel)
      3'd0:    mux_d = d0;
      3'd1:    mux_d = d1;
      3'd2:    mux_d = d2;
      3'd3:    mux_d = d3;
      3'd4:    mux_d = d4;
      3'd5:    mux_d = d5;
      default: sel_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q         <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
    end else if (in_valid) begin
      q         <= mux_d;
      out_valid <= 1'b1;
      sel_err   <= ~sel_legal;
    end else begin
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
    end
  end

`ifdef SIX_ONE_MUX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_par <= 1'b0;
    end else if (in_valid) begin
      q_par <= ^mux_d;
    end
  end
`endif

endmodule

// File: tb/tb_six_one_mux.sv
// tb/tb_six_one_mux.sv - directed vector bench for six_one_mux (WIDTH=8)
module tb_six_one_mux;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [2:0]   sel;
  logic [W-1:0] d0, d1, d2, d3, d4, d5;
  logic [W-1:0] q;
  logic         out_valid;
  logic         sel_err;
`ifdef SIX_ONE_MUX_PARITY_EN
  logic         q_par;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  six_one_mux #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .sel       (sel),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .d4        (d4),
    .d5        (d5),
    .q         (q),
    .out_valid (out_valid),
`ifdef SIX_ONE_MUX_PARITY_EN
    .q_par     (q_par),
`endif
    .sel_err   (sel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [2:0]   s;
    logic [5:0][W-1:0] d;
    logic [W-1:0] exp_q;
    logic         exp_ov;
    logic         exp_err;
    logic         exp_par;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [5:0][W-1:0] pk(input logic [W-1:0] a0, a1, a2, a3, a4, a5);
    return {a5, a4, a3, a2, a1, a0};
  endfunction

  function automatic vec_t mk(input logic v, input logic [2:0] s, input logic [5:0][W-1:0] d,
                              input logic [W-1:0] eq, input logic eov, eerr, epar);
    vec_t r;
    r.v = v; r.s = s; r.d = d; r.exp_q = eq; r.exp_ov = eov; r.exp_err = eerr; r.exp_par = epar;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [5:0][W-1:0] d);
    in_valid = v; sel = s;
    d0 = d[0]; d1 = d[1]; d2 = d[2]; d3 = d[3]; d4 = d[4]; d5 = d[5];
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] eq, input logic eov, eerr, epar);
    chk({tag, ".q"}, 32'(q), 32'(eq));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(eov));
    chk({tag, ".sel_err"}, 32'(sel_err), 32'(eerr));
`ifdef SIX_ONE_MUX_PARITY_EN
    chk({tag, ".q_par"}, 32'(q_par), 32'(epar));
`else
    if (epar === 1'bx) $display("note: unused parity expectation");
`endif
  endtask

  initial begin
    logic [5:0][W-1:0] dd;
    logic [5:0][W-1:0] ones;
    dd   = pk(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66);
    ones = pk(8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01);

    vecs.push_back(mk(1, 3'd0, pk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01), 8'h00, 1, 0, 0));
    vecs.push_back(mk(1, 3'd1, pk(8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01), 8'h01, 1, 0, 1));
    vecs.push_back(mk(1, 3'd3, pk(8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00), 8'h01, 1, 0, 1));
    vecs.push_back(mk(1, 3'd5, pk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01), 8'h01, 1, 0, 1));
    vecs.push_back(mk(1, 3'd6, ones, 8'h00, 1, 1, 0));
    vecs.push_back(mk(0, 3'd1, ones, 8'h00, 0, 0, 0));
    vecs.push_back(mk(1, 3'd0, dd, 8'h11, 1, 0, 0));
    vecs.push_back(mk(1, 3'd1, dd, 8'h22, 1, 0, 0));
    vecs.push_back(mk(1, 3'd2, dd, 8'h33, 1, 0, 0));
    vecs.push_back(mk(1, 3'd3, dd, 8'h44, 1, 0, 0));
    vecs.push_back(mk(1, 3'd4, dd, 8'h55, 1, 0, 0));
    vecs.push_back(mk(1, 3'd5, dd, 8'h66, 1, 0, 0));
    vecs.push_back(mk(1, 3'd7, dd, 8'h00, 1, 1, 0));
    vecs.push_back(mk(1, 3'd2, pk(8'h00, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00), 8'hA5, 1, 0, 0));
    vecs.push_back(mk(1, 3'd4, pk(8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00), 8'h01, 1, 0, 1));
    vecs.push_back(mk(0, 3'd5, dd, 8'h01, 0, 0, 1));
    vecs.push_back(mk(0, 3'bxxx, dd, 8'h01, 0, 0, 1));
    vecs.push_back(mk(1, 3'd3, pk(8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00), 8'h07, 1, 0, 1));
    vecs.push_back(mk(1, 3'd1, pk(8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00), 8'hFF, 1, 0, 0));

    rst_n = 1'b0;
    drive(0, 3'd0, dd);
    #2;
    check_out("reset", 8'h00, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].s, vecs[i].d);
      @(posedge clk);
      #1;
      check_out($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_ov, vecs[i].exp_err, vecs[i].exp_par);
    end

    // Hold: q must survive idle cycles while d1 and sel wander.
    @(negedge clk);
    drive(1, 3'd1, pk(8'h00, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00));
    @(posedge clk); #1;
    check_out("hold_load", 8'h5A, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(0, 3'(k), pk(8'h00, 8'(8'hC3 ^ k), 8'h00, 8'h00, 8'h00, 8'h00));
      @(posedge clk); #1;
      check_out($sformatf("hold%0d", k), 8'h5A, 0, 0, 0);
    end

    // Mid-cycle async reset with q nonzero and out_valid high.
    @(negedge clk);
    drive(1, 3'd5, pk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h81));
    @(posedge clk); #1;
    check_out("pre_rst", 8'h81, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 8'h00, 0, 0, 0);
    @(posedge clk); #1;
    check_out("rst_held", 8'h00, 0, 0, 0);

    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 3'd2, pk(8'h00, 8'h00, 8'h3C, 8'h00, 8'h00, 8'h00));
    @(posedge clk); #1;
    check_out("post_rst", 8'h3C, 1, 0, 0);
    @(negedge clk);
    drive(0, 3'd0, dd);
    @(posedge clk); #1;
    check_out("post_rst_idle", 8'h3C, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/six_one_mux.md
Name: six_one_mux

Overview:
- Registered 6-to-1 data multiplexer with one cycle of latency.
- Selects one of six WIDTH-bit inputs (d0..d5) using a 3-bit select code, qualified by a valid strobe.
- Flags out-of-range select codes.
- Used as a generic datapath steering element wherever six sources share one sink register.

Parameters:
- WIDTH, default 1, bit width of each data input and of q.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  qualifies sel and d0..d5 this cycle
- sel  input  3  select code; 0..5 pick d0..d5, 6..7 illegal
- d0  input  WIDTH  data source 0
- d1  input  WIDTH  data source 1
- d2  input  WIDTH  data source 2
- d3  input  WIDTH  data source 3
- d4  input  WIDTH  data source 4
- d5  input  WIDTH  data source 5
- q  output  WIDTH  registered selected data
- out_valid  output  1  q updated by a valid transfer in the previous cycle
- sel_err  output  1  previous valid transfer used an illegal sel code

Behaviour:
- Reset: one clock (clk); reset rst_n is asynchronous and active-low.
  - While rst_n=0: q=0, out_valid=0, sel_err=0 immediately, independent of clk.
  - Deassertion is sampled on the next rising clk edge.
- Latency is 1 cycle. Inputs are sampled on rising clk; outputs change only on rising clk or on reset.
- in_valid=1 and sel in 0..5:
  - q <= d[sel], e.g. sel=3 gives q <= d3.
  - out_valid <= 1, sel_err <= 0.
- in_valid=1 and sel = 6 or 7:
  - q <= 0, out_valid <= 1, sel_err <= 1.
- in_valid=0:
  - q holds its previous value.
  - out_valid <= 0, sel_err <= 0.
  - sel and d0..d5 are ignored.
- out_valid and sel_err are single-cycle pulses per transfer. Back-to-back valid cycles give back-to-back updates; there is no backpressure.
- Full-width pass-through: there is no arithmetic, and every bit of the selected input is copied unchanged.
- X on sel while in_valid=0 has no effect on outputs.
- Reset asserted mid-stream clears all outputs at once. The first valid transfer after release produces output one cycle later.
- Implementation: purely combinational selection into a single register stage. No internal state other than the output registers.

Optional Feature:
- Macro SIX_ONE_MUX_PARITY_EN.
- When defined:
  - Adds output q_par (1 bit).
  - q_par is registered alongside q and equals the XOR of all bits of the value loaded into q (even parity). It is 0 for the zeroed illegal-select case.
  - q_par holds with q when in_valid=0 and resets to 0.
- When undefined: port q_par does not exist, and behaviour is otherwise identical.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with q previously 1 -> q=0, out_valid=0, sel_err=0 immediately, without a clock edge.
- Select 0, WIDTH=1: d0=0, d5=1, sel=0, in_valid=1 -> next cycle q=0, out_valid=1, sel_err=0.
- Select 1: d1=1, d5=1, all others 0, sel=1, in_valid=1 -> next cycle q=1. Repeat with d3=1, sel=3 -> q=1. Repeat with d5=1, sel=5 -> q=1.
- Illegal select: all d=1, sel=6, in_valid=1 -> next cycle q=0, sel_err=1, out_valid=1. The following cycle with in_valid=0 -> sel_err=0, out_valid=0, q stays 0.
- Hold: load q=1 via sel=1, then hold in_valid=0 for 3 cycles while toggling d1 and sel -> q stays 1, out_valid=0.
- Width and parity: WIDTH=8, d2=8'hA5, sel=2, in_valid=1 -> q=8'hA5. With SIX_ONE_MUX_PARITY_EN defined, q_par=0. Then d4=8'h01, sel=4 -> q=8'h01, q_par=1.
